// File: rtl/vga_timing_pkg.sv
// VGA timing constants (640x480@60 defaults) shared by the sync generator and the
// renderers, plus a small inclusive-range helper used for screen-bound decodes.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
   localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

   localparam int   DEF_CLK_DIV  = 4;
   localparam logic DEF_SYNC_POL = 1'b0;

   function automatic logic in_span(input logic [COORD_W-1:0] v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate prescaler: one-clock pulse every CLK_DIV system clocks; the first pulse
// appears CLK_DIV clocks after reset is released.
module vga_pixel_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic srst,
   output logic pixel_tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_reg;
   logic             tick_reg;
   logic             at_last;

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_pixel_tick: CLK_DIV must be >= 1");
   end

   assign at_last = (count_reg == LAST);

   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg <= '0;
         tick_reg  <= 1'b0;
      end else begin
         count_reg <= at_last ? '0 : count_reg + 1'b1;
         tick_reg  <= at_last;
      end
   end

   assign pixel_tick = tick_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel/line counters with registered sync and video-enable decode.
// Define VGA_SYNC_DELAY_EN to add one register stage on hsync/vsync/videoON only.
module vga_sync_gen import vga_timing_pkg::*; #(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter int   CLK_DIV  = DEF_CLK_DIV,
   parameter logic SYNC_POL = DEF_SYNC_POL
) (
   input  logic               clock,
   input  logic               reset,
   output logic               pixelTick,
   output logic [COORD_W-1:0] pixelX,
   output logic [COORD_W-1:0] pixelY,
   output logic               videoON,
   output logic               hsync,
   output logic               vsync,
   output logic               frameStart
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   // Bit order {hsync, vsync, videoON}; idle is deasserted sync and blanked video.
   localparam logic [2:0] SYNC_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

   if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   logic               tick;
   logic [COORD_W-1:0] x_reg, x_next;
   logic [COORD_W-1:0] y_reg, y_next;
   logic               line_end, frame_end;
   logic [2:0]         sync_reg, sync_next;
   logic               frame_reg;

   vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
      .clk        (clock),
      .srst       (reset),
      .pixel_tick (tick)
   );

   always_comb begin
      x_next    = x_reg;
      y_next    = y_reg;
      line_end  = (x_reg == COORD_W'(H_TOTAL - 1));
      frame_end = line_end && (y_reg == COORD_W'(V_TOTAL - 1));
      if (tick) begin
         if (line_end) begin
            x_next = '0;
            y_next = frame_end ? '0 : y_reg + 1'b1;
         end else begin
            x_next = x_reg + 1'b1;
         end
      end
   end

   // Decoding the next-state counters lets the registered outputs line up with pixelX/pixelY.
   always_comb begin
      sync_next    = SYNC_IDLE;
      sync_next[2] = in_span(x_next, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      sync_next[1] = in_span(y_next, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      sync_next[0] = in_span(x_next, 0, H_ACTIVE - 1) && in_span(y_next, 0, V_ACTIVE - 1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_reg     <= '0;
         y_reg     <= '0;
         sync_reg  <= SYNC_IDLE;
         frame_reg <= 1'b0;
      end else begin
         x_reg     <= x_next;
         y_reg     <= y_next;
         sync_reg  <= sync_next;
         frame_reg <= tick && frame_end;
      end
   end

`ifdef VGA_SYNC_DELAY_EN
   logic [2:0] sync_dly_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_dly_reg <= SYNC_IDLE;
      end else begin
         sync_dly_reg <= sync_reg;
      end
   end

   assign hsync   = sync_dly_reg[2];
   assign vsync   = sync_dly_reg[1];
   assign videoON = sync_dly_reg[0];
`else
   assign hsync   = sync_reg[2];
   assign vsync   = sync_reg[1];
   assign videoON = sync_reg[0];
`endif

   assign pixelTick  = tick;
   assign pixelX     = x_reg;
   assign pixelY     = y_reg;
   assign frameStart = frame_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default timing at CLK_DIV=4 and 1, plus a reduced geometry for frame tests.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
   localparam int LAG = 1;
`else
   localparam int LAG = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, rst_c;
   logic       a_tick, a_video, a_hs, a_vs, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_tick, b_video, b_hs, b_vs, b_fs;
   logic [9:0] b_x, b_y;
   logic       c_tick, c_video, c_hs, c_vs, c_fs;
   logic [9:0] c_x, c_y;

   vga_sync_gen dut_a (
      .clock(clk), .reset(rst_a), .pixelTick(a_tick), .pixelX(a_x), .pixelY(a_y),
      .videoON(a_video), .hsync(a_hs), .vsync(a_vs), .frameStart(a_fs)
   );

   // Small frame: 16 x 10 totals, hsync x in [10,12], vsync y in [7,8], tick every clock.
   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(1), .SYNC_POL(1'b0)
   ) dut_b (
      .clock(clk), .reset(rst_b), .pixelTick(b_tick), .pixelX(b_x), .pixelY(b_y),
      .videoON(b_video), .hsync(b_hs), .vsync(b_vs), .frameStart(b_fs)
   );

   vga_sync_gen #(.CLK_DIV(1)) dut_c (
      .clock(clk), .reset(rst_c), .pixelTick(c_tick), .pixelX(c_x), .pixelY(c_y),
      .videoON(c_video), .hsync(c_hs), .vsync(c_vs), .frameStart(c_fs)
   );

   typedef struct {
      int   x;
      logic video;
      logic hs;
      logic vs;
   } vec_t;

   vec_t tbl[8];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_a(input int x, output bit found);
      found = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (a_tick && int'(a_x) == x) begin
            found = 1'b1;
            break;
         end
         step(1);
      end
   endtask

   task automatic tick_latency_a(input string name);
      int n;
      n = 1;
      while (!a_tick && n < 20) begin
         step(1);
         n++;
      end
      check(name, n, 4);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  ticks, hs_ticks, hs_first, vid_fall, lc, hl, tk, c, fs1, fs2;
      int  prev_x, prev_y;
      int  hs656, hs657, v640, v641;
      logic [9:0] vmask;
      bit  found;

      tbl[0] = '{0,   1'b1, 1'b1, 1'b1};
      tbl[1] = '{639, 1'b1, 1'b1, 1'b1};
      tbl[2] = '{640, 1'b0, 1'b1, 1'b1};
      tbl[3] = '{655, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{656, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{751, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{752, 1'b0, 1'b1, 1'b1};
      tbl[7] = '{799, 1'b0, 1'b1, 1'b1};

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Reset state and release behaviour, default timing
      step(5);
      check("A reset pixelX", a_x, 0);
      check("A reset pixelY", a_y, 0);
      check("A reset pixelTick", a_tick, 0);
      check("A reset frameStart", a_fs, 0);
      check("A reset videoON", a_video, 0);
      check("A reset hsync", a_hs, 1);
      check("A reset vsync", a_vs, 1);
      rst_a = 1'b0;
      step(1);
      check("A release pixelX", a_x, 0);
      check("A release pixelY", a_y, 0);
      check("A release videoON", a_video, (LAG == 0) ? 1 : 0);
      check("A release hsync", a_hs, 1);
      check("A release vsync", a_vs, 1);
      check("A release frameStart", a_fs, 0);
      tick_latency_a("A first tick latency");

      // One full line: tick count, hsync width/start, videoON fall
      ticks = 0; hs_ticks = 0; hs_first = -1; vid_fall = -1;
      for (int k = 0; k < 4000; k++) begin
         if (a_tick) begin
            ticks++;
            if (!a_hs) begin
               if (hs_ticks == 0) hs_first = int'(a_x);
               hs_ticks++;
            end
            if (!a_video && vid_fall < 0) vid_fall = int'(a_x);
         end
         if (ticks == 800) break;
         step(1);
      end
      check("A ticks per line", ticks, 800);
      check("A hsync low ticks", hs_ticks, 96);
      check("A hsync start x", hs_first, 656);
      check("A videoON fall x", vid_fall, 640);
      step(1);
      check("A line wrap pixelX", a_x, 0);
      check("A line wrap pixelY", a_y, 1);

      // Decode points along line 1
      for (int i = 0; i < 8; i++) begin
         wait_a(tbl[i].x, found);
         check($sformatf("A x=%0d reached", tbl[i].x), found, 1);
         check($sformatf("A x=%0d pixelY", tbl[i].x), a_y, 1);
         check($sformatf("A x=%0d videoON", tbl[i].x), a_video, tbl[i].video);
         check($sformatf("A x=%0d hsync", tbl[i].x), a_hs, tbl[i].hs);
         check($sformatf("A x=%0d vsync", tbl[i].x), a_vs, tbl[i].vs);
      end

      // Reset pulse in the middle of hsync
      wait_a(700, found);
      check("A x=700 reached", found, 1);
      check("A x=700 hsync", a_hs, 0);
      rst_a = 1'b1;
      step(1);
      rst_a = 1'b0;
      check("A midreset pixelX", a_x, 0);
      check("A midreset pixelY", a_y, 0);
      check("A midreset hsync", a_hs, 1);
      check("A midreset pixelTick", a_tick, 0);
      check("A midreset videoON", a_video, 0);
      step(1);
      check("A re-release pixelX", a_x, 0);
      check("A re-release videoON", a_video, (LAG == 0) ? 1 : 0);
      check("A re-release hsync", a_hs, 1);
      tick_latency_a("A re-release tick latency");
      step(1);
      check("A resumed pixelX", a_x, 1);

      // CLK_DIV=1, default geometry: 800-clock line and sync/video edge placement
      step(1);
      rst_c = 1'b0;
      step(1);
      check("C release pixelTick", c_tick, 1);
      check("C release pixelX", c_x, 0);
      lc = 0; hl = 0; tk = 0; hs656 = -1; hs657 = -1; v640 = -1; v641 = -1;
      do begin
         step(1);
         lc++;
         if (!c_hs) hl++;
         if (c_tick) tk++;
         if (c_x == 10'd656) hs656 = int'(c_hs);
         if (c_x == 10'd657) hs657 = int'(c_hs);
         if (c_x == 10'd640) v640 = int'(c_video);
         if (c_x == 10'd641) v641 = int'(c_video);
      end while (c_x != 10'd0 && lc < 2000);
      check("C clocks per line", lc, 800);
      check("C ticks per line", tk, 800);
      check("C hsync low clocks", hl, 96);
      check("C hsync at x=656", hs656, (LAG == 0) ? 0 : 1);
      check("C hsync at x=657", hs657, 0);
      check("C videoON at x=640", v640, (LAG == 0) ? 0 : 1);
      check("C videoON at x=641", v641, 0);
      check("C next line pixelY", c_y, 1);

      // Reduced geometry: full frames, vsync lines, frameStart period and wrap corner
      rst_b = 1'b0;
      step(1);
      check("B release frameStart", b_fs, 0);
      check("B release pixelX", b_x, 0);
      c = 1; fs1 = -1; fs2 = -1; vmask = '0; lc = 0; prev_x = -1; prev_y = -1;
      while (fs2 < 0 && c < 600) begin
         prev_x = int'(b_x);
         prev_y = int'(b_y);
         step(1);
         c++;
         if (fs1 < 0 && b_x == 10'd4) begin
            lc++;
            if (!b_vs) vmask[b_y] = 1'b1;
         end
         if (b_fs) begin
            if (fs1 < 0) fs1 = c;
            else fs2 = c;
         end
      end
      check("B first frameStart clock", fs1, 161);
      check("B frameStart period", fs2 - fs1, 160);
      check("B lines per frame", lc, 10);
      check("B vsync line mask", vmask, 10'h180);
      check("B before wrap pixelX", prev_x, 15);
      check("B before wrap pixelY", prev_y, 9);
      check("B wrap pixelX", b_x, 0);
      check("B wrap pixelY", b_y, 0);
      check("B wrap frameStart", b_fs, 1);
      check("B wrap videoON", b_video, (LAG == 0) ? 1 : 0);
      step(1);
      check("B after wrap frameStart", b_fs, 0);
      check("B after wrap videoON", b_video, 1);
      check("B after wrap pixelX", b_x, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
